// File: rtl/bus_router.sv
// bus_router: registered one-word transfer engine between the control unit and N bus units.
// Define BUS_ROUTER_TIMEOUT_EN to add the source-wait watchdog.
module bus_router #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ID_W-1:0]           i_write_id,
  input  logic [ID_W-1:0]           i_read_id,
  input  logic [CMD_W-1:0]          i_write_cmd,
  input  logic [CMD_W-1:0]          i_read_cmd,
  output logic [N_UNITS*CMD_W-1:0]  o_unit_cmd,
  output logic [N_UNITS-1:0]        o_unit_cmd_en,
  input  logic [N_UNITS*DATA_W-1:0] i_unit_data,
  input  logic [N_UNITS-1:0]        i_unit_valid,
  output logic [DATA_W-1:0]         o_unit_data,
  output logic [N_UNITS-1:0]        o_unit_valid,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int unsigned ID_EXT_W = ID_W + 1;

  if (((2 ** ID_W) < N_UNITS) || (TIMEOUT == 0)) begin : g_bad_params
    $error("bus_router: ID_W too narrow for N_UNITS or TIMEOUT is zero");
  end

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_SNK} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     wid_q, rid_q;
  logic [CMD_W-1:0]    wcmd_q, rcmd_q;
  logic                accept_c, bad_id_c, src_valid_c, timeout_c;
  logic [DATA_W-1:0]   src_data_c;
  logic                sel_on_c;
  logic [ID_W-1:0]     sel_id_c;
  logic [CMD_W-1:0]    sel_cmd_c;
  logic [N_UNITS*CMD_W-1:0] cmd_d;
  logic [N_UNITS-1:0]  cmd_en_d, valid_d;
  logic                done_d, err_d;

  assign accept_c = o_req_ready & i_req_valid;
  assign bad_id_c = (ID_EXT_W'(i_write_id) >= ID_EXT_W'(N_UNITS)) ||
                    (ID_EXT_W'(i_read_id)  >= ID_EXT_W'(N_UNITS));

  // Pick the latched source unit's valid and data off the bus.
  always_comb begin
    src_valid_c = 1'b0;
    src_data_c  = '0;
    for (int unsigned k = 0; k < N_UNITS; k++) begin
      if (wid_q == ID_W'(k)) begin
        src_valid_c = i_unit_valid[k];
        src_data_c  = i_unit_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef BUS_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // The TIMEOUT-th idle source cycle aborts unless valid shows up in that same cycle.
  assign timeout_c = (state_q == S_SRC) && !src_valid_c && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= '0;
    end else if ((state_q == S_SRC) && !src_valid_c) begin
      cnt_q <= timeout_c ? '0 : cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and next registered outputs; a single unit is addressed per cycle.
  always_comb begin
    state_d   = state_q;
    sel_on_c  = 1'b0;
    sel_id_c  = wid_q;
    sel_cmd_c = wcmd_q;
    cmd_d     = '0;
    cmd_en_d  = '0;
    valid_d   = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bad_id_c) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d   = S_SRC;
            sel_on_c  = 1'b1;
            sel_id_c  = i_write_id;
            sel_cmd_c = i_write_cmd;
          end
        end
      end
      S_SRC: begin
        if (src_valid_c) begin
          state_d   = S_SNK;
          sel_on_c  = 1'b1;
          sel_id_c  = rid_q;
          sel_cmd_c = rcmd_q;
          done_d    = 1'b1;
        end else if (timeout_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          sel_on_c = 1'b1;
        end
      end
      S_SNK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    for (int unsigned k = 0; k < N_UNITS; k++) begin
      if (sel_on_c && (sel_id_c == ID_W'(k))) begin
        cmd_en_d[k]                = 1'b1;
        cmd_d[k*CMD_W +: CMD_W]    = sel_cmd_c;
        valid_d[k]                 = (state_d == S_SNK);
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= S_IDLE;
      wid_q         <= '0;
      rid_q         <= '0;
      wcmd_q        <= '0;
      rcmd_q        <= '0;
      o_req_ready   <= 1'b1;
      o_unit_cmd    <= '0;
      o_unit_cmd_en <= '0;
      o_unit_data   <= '0;
      o_unit_valid  <= '0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_req_ready   <= (state_d == S_IDLE) && !done_d;
      o_unit_cmd    <= cmd_d;
      o_unit_cmd_en <= cmd_en_d;
      o_unit_valid  <= valid_d;
      o_done        <= done_d;
      o_err         <= err_d;
      if (accept_c) begin
        wid_q  <= i_write_id;
        rid_q  <= i_read_id;
        wcmd_q <= i_write_cmd;
        rcmd_q <= i_read_cmd;
      end
      if ((state_q == S_SRC) && src_valid_c) begin
        o_unit_data <= src_data_c;
      end
    end
  end

endmodule

// File: tb/tb_bus_router.sv
// Randomised self-checking bench for bus_router against a per-cycle transaction model.
module tb_bus_router;

  localparam int unsigned N_UNITS = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned TIMEOUT = 15;

  typedef struct packed {
    logic                     ready;
    logic [N_UNITS-1:0]       cmd_en;
    logic [N_UNITS*CMD_W-1:0] cmd;
    logic [N_UNITS-1:0]       valid;
    logic                     done;
    logic                     err;
    logic [DATA_W-1:0]        data;
  } obs_t;

  typedef struct {
    int                wid;
    int                rid;
    int                wcmd;
    int                rcmd;
    int                delay;
    logic [DATA_W-1:0] data;
  } xfer_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      i_req_valid;
  logic                      o_req_ready;
  logic [ID_W-1:0]           i_write_id, i_read_id;
  logic [CMD_W-1:0]          i_write_cmd, i_read_cmd;
  logic [N_UNITS*CMD_W-1:0]  o_unit_cmd;
  logic [N_UNITS-1:0]        o_unit_cmd_en;
  logic [N_UNITS*DATA_W-1:0] i_unit_data;
  logic [N_UNITS-1:0]        i_unit_valid;
  logic [DATA_W-1:0]         o_unit_data;
  logic [N_UNITS-1:0]        o_unit_valid;
  logic                      o_done, o_err;

  obs_t              obs;
  int                n_vec;
  int                n_err;
  logic [DATA_W-1:0] last_data;

  always #5 clk = ~clk;

  bus_router #(
    .N_UNITS(N_UNITS), .DATA_W(DATA_W), .CMD_W(CMD_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_write_id(i_write_id), .i_read_id(i_read_id),
    .i_write_cmd(i_write_cmd), .i_read_cmd(i_read_cmd),
    .o_unit_cmd(o_unit_cmd), .o_unit_cmd_en(o_unit_cmd_en),
    .i_unit_data(i_unit_data), .i_unit_valid(i_unit_valid),
    .o_unit_data(o_unit_data), .o_unit_valid(o_unit_valid),
    .o_done(o_done), .o_err(o_err)
  );

  assign obs = {o_req_ready, o_unit_cmd_en, o_unit_cmd, o_unit_valid, o_done, o_err, o_unit_data};

  // Number of source-phase cycles a transfer occupies (0 when rejected for a bad ID).
  function automatic int src_cycles(input xfer_t x);
    if ((x.wid >= int'(N_UNITS)) || (x.rid >= int'(N_UNITS))) return 0;
`ifdef BUS_ROUTER_TIMEOUT_EN
    if (x.delay >= int'(TIMEOUT)) return int'(TIMEOUT);
`endif
    return x.delay + 1;
  endfunction

  function automatic bit delivers(input xfer_t x);
    if (src_cycles(x) == 0) return 1'b0;
`ifdef BUS_ROUTER_TIMEOUT_EN
    if (x.delay >= int'(TIMEOUT)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Expected outputs in cycle c of a transfer (c=0 is the accepting idle cycle).
  function automatic obs_t model(input xfer_t x, input int c, input logic [DATA_W-1:0] prev);
    obs_t e;
    int   s;
    bit   ok;
    e  = '0;
    s  = src_cycles(x);
    ok = delivers(x);
    e.data = (ok && (c > s)) ? x.data : prev;
    if ((c == 0) || (c > s + 1)) begin
      e.ready = 1'b1;
    end else if (c <= s) begin
      e.cmd_en[x.wid]                 = 1'b1;
      e.cmd[x.wid*CMD_W +: CMD_W]     = CMD_W'(x.wcmd);
    end else if (ok) begin
      e.valid[x.rid]                  = 1'b1;
      e.cmd_en[x.rid]                 = 1'b1;
      e.cmd[x.rid*CMD_W +: CMD_W]     = CMD_W'(x.rcmd);
      e.done                          = 1'b1;
    end else begin
      e.done = 1'b1;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Inputs for cycle c: the request, then random bus noise with the source valid at delay+1.
  task automatic drive_cycle(input xfer_t x, input int c);
    logic [N_UNITS-1:0]        v;
    logic [N_UNITS*DATA_W-1:0] d;
    v = N_UNITS'($urandom);
    for (int k = 0; k < int'(N_UNITS); k++) d[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    if ((x.wid < int'(N_UNITS)) && (c >= 1) && (c <= x.delay + 1)) begin
      v[x.wid]                      = (c == x.delay + 1);
      d[x.wid*DATA_W +: DATA_W]     = x.data;
    end
    i_unit_valid = v;
    i_unit_data  = d;
    if (c == 0) begin
      i_req_valid = 1'b1;
      i_write_id  = ID_W'(x.wid);
      i_read_id   = ID_W'(x.rid);
      i_write_cmd = CMD_W'(x.wcmd);
      i_read_cmd  = CMD_W'(x.rcmd);
    end else if (c <= src_cycles(x) + 1) begin
      i_req_valid = 1'($urandom);
      i_write_id  = ID_W'($urandom);
      i_read_id   = ID_W'($urandom);
      i_write_cmd = CMD_W'($urandom);
      i_read_cmd  = CMD_W'($urandom);
    end else begin
      i_req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    obs_t m, e;
    i_req_valid = 1'b0; i_write_id = '0; i_read_id = '0; i_write_cmd = '0; i_read_cmd = '0;
    i_unit_valid = '0; i_unit_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m = obs; m.ready = 1'b0;
    n_vec++;
    if (m !== '0) begin n_err++; $display("FAIL reset_hold got=%h exp=0 (ready ignored)", m); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = '0; e.ready = 1'b1;
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    last_data = '0;
  endtask

  task automatic test_basic();
    xfer_t x; obs_t e;
    x = '{wid:1, rid:2, wcmd:3, rcmd:5, delay:0, data:16'hBEEF};
    for (int c = 0; c <= src_cycles(x) + 2; c++) begin
      drive_cycle(x, c);
      e = model(x, c, last_data);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL basic c=%0d got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    e = model(x, src_cycles(x) + 2, last_data); last_data = e.data;
  endtask

  task automatic test_delayed_source();
    xfer_t x; obs_t e;
    x = '{wid:0, rid:3, wcmd:9, rcmd:2, delay:3, data:16'h1234};
    for (int c = 0; c <= src_cycles(x) + 2; c++) begin
      drive_cycle(x, c);
      e = model(x, c, last_data);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL delayed c=%0d got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    e = model(x, src_cycles(x) + 2, last_data); last_data = e.data;
  endtask

  task automatic test_same_unit();
    xfer_t x; obs_t e;
    x = '{wid:3, rid:3, wcmd:4, rcmd:12, delay:1, data:16'h00FF};
    for (int c = 0; c <= src_cycles(x) + 2; c++) begin
      drive_cycle(x, c);
      e = model(x, c, last_data);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL same_unit c=%0d got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
    e = model(x, src_cycles(x) + 2, last_data); last_data = e.data;
  endtask

  task automatic test_invalid_id();
    xfer_t list[2]; obs_t e;
    list[0] = '{wid:1, rid:6, wcmd:7, rcmd:7, delay:0, data:16'hDEAD};
    list[1] = '{wid:4, rid:0, wcmd:1, rcmd:2, delay:0, data:16'hCAFE};
    foreach (list[i]) begin
      for (int c = 0; c <= src_cycles(list[i]) + 2; c++) begin
        drive_cycle(list[i], c);
        e = model(list[i], c, last_data);
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL invalid_id%0d c=%0d got=%h exp=%h", i, c, obs, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    xfer_t x; obs_t e;
    for (int i = 0; i < 6; i++) begin
      x = '{wid:i % 4, rid:(i + 1) % 4, wcmd:i, rcmd:15 - i, delay:0, data:DATA_W'($urandom)};
      for (int c = 0; c <= src_cycles(x) + 1; c++) begin
        drive_cycle(x, c);
        e = model(x, c, last_data);
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL b2b%0d c=%0d got=%h exp=%h", i, c, obs, e); end
        @(posedge clk); #1;
      end
      e = model(x, src_cycles(x) + 2, last_data); last_data = e.data;
    end
    drive_cycle(x, src_cycles(x) + 2);
    e = model(x, src_cycles(x) + 2, last_data);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL b2b_tail got=%h exp=%h", obs, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    xfer_t x; obs_t e;
    for (int i = 0; i < 30; i++) begin
      x.wid   = int'($urandom_range(0, N_UNITS));
      x.rid   = int'($urandom_range(0, N_UNITS));
      x.wcmd  = int'($urandom_range(0, 15));
      x.rcmd  = int'($urandom_range(0, 15));
      x.delay = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      x.data  = DATA_W'($urandom);
      for (int c = 0; c <= src_cycles(x) + 2; c++) begin
        drive_cycle(x, c);
        e = model(x, c, last_data);
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL random%0d c=%0d got=%h exp=%h", i, c, obs, e); end
        @(posedge clk); #1;
      end
      e = model(x, src_cycles(x) + 2, last_data); last_data = e.data;
    end
  endtask

`ifdef BUS_ROUTER_TIMEOUT_EN
  task automatic test_timeout();
    xfer_t list[2]; obs_t e;
    list[0] = '{wid:2, rid:1, wcmd:6, rcmd:3, delay:int'(TIMEOUT) + 5, data:16'hAAAA};
    list[1] = '{wid:2, rid:1, wcmd:6, rcmd:3, delay:int'(TIMEOUT) - 1, data:16'h5A5A};
    foreach (list[i]) begin
      for (int c = 0; c <= src_cycles(list[i]) + 2; c++) begin
        drive_cycle(list[i], c);
        e = model(list[i], c, last_data);
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL timeout%0d c=%0d got=%h exp=%h", i, c, obs, e); end
        @(posedge clk); #1;
      end
      e = model(list[i], src_cycles(list[i]) + 2, last_data); last_data = e.data;
    end
  endtask
`endif

  task automatic test_reset_mid();
    xfer_t x; obs_t e, m;
    x = '{wid:2, rid:0, wcmd:8, rcmd:1, delay:50, data:16'h7777};
    for (int c = 0; c <= 3; c++) begin
      drive_cycle(x, c);
      e = model(x, c, last_data);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, obs, e); end
      if (c < 3) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    i_req_valid = 1'b0;
    #1;
    m = obs; m.ready = 1'b0;
    n_vec++;
    if (m !== '0) begin n_err++; $display("FAIL reset_mid_async got=%h exp=0 (ready ignored)", m); end
    @(posedge clk); #1;
    m = obs; m.ready = 1'b0;
    n_vec++;
    if (m !== '0) begin n_err++; $display("FAIL reset_mid_hold got=%h exp=0 (ready ignored)", m); end
    rst_n = 1'b1;
    last_data = '0;
    @(posedge clk); #1;
    x = '{wid:0, rid:1, wcmd:10, rcmd:11, delay:2, data:16'h4321};
    for (int c = 0; c <= src_cycles(x) + 2; c++) begin
      drive_cycle(x, c);
      e = model(x, c, last_data);
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL reset_mid_post c=%0d got=%h exp=%h", c, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    last_data = '0;
    test_reset();
    test_basic();
    test_delayed_source();
    test_same_unit();
    test_invalid_id();
    test_back_to_back();
    test_random();
`ifdef BUS_ROUTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_router.md
# bus_router

Parametrised, registered successor to the single-cycle top-level bus mux. Moves one word per transaction from a source unit (write_id) to a sink unit (read_id) over a shared N-unit bus. Sequenced by a small FSM with a request/ready handshake toward the control unit, a capture register, and an optional source-timeout watchdog. Sits between the control unit and all bus-attached units (ALU, register file, debug port, …).

## Interface
- N_UNITS, 4: number of bus-attached units; unit IDs are 0..N_UNITS-1.
- DATA_W, 16: bus word width.
- CMD_W, 4: unit command width.
- ID_W, 4: unit ID width; must satisfy 2**ID_W >= N_UNITS.
- TIMEOUT, 15: maximum source-wait cycles (used only with BUS_ROUTER_TIMEOUT_EN).
- i_Clk  in  1  clock; all logic on the rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  control unit presents a transfer.
- o_req_ready  out  1  router can accept a transfer.
- i_write_id  in  ID_W  source unit.
- i_read_id  in  ID_W  sink unit.
- i_write_cmd  in  CMD_W  command for the source.
- i_read_cmd  in  CMD_W  command for the sink.
- o_unit_cmd  out  N_UNITS*CMD_W  per-unit command; slice k = [k*CMD_W +: CMD_W].
- o_unit_cmd_en  out  N_UNITS  per-unit command strobe.
- i_unit_data  in  N_UNITS*DATA_W  per-unit output data.
- i_unit_valid  in  N_UNITS  per-unit output valid.
- o_unit_data  out  DATA_W  shared bus data to all units.
- o_unit_valid  out  N_UNITS  per-unit input valid (one-hot or zero).
- o_done  out  1  one-cycle pulse: transaction finished.
- o_err  out  1  one-cycle pulse with o_done: transaction failed.

## Operation
- States: IDLE, SRC, SNK.
- IDLE: o_req_ready=1. On i_req_valid: latch both IDs and both commands, go to SRC. If either latched ID >= N_UNITS: go to IDLE instead, with o_done=o_err=1 the following cycle.
- SRC: o_unit_cmd_en[wid]=1, o_unit_cmd[wid]=wcmd; all other strobes 0. When i_unit_valid[wid]=1 that cycle: capture i_unit_data[wid] into the data register, go to SNK.
- SNK (exactly one cycle): o_unit_data=captured word, o_unit_valid[rid]=1, o_unit_cmd_en[rid]=1, o_unit_cmd[rid]=rcmd, o_done=1, o_err=0. Then go to IDLE.
- wid==rid is legal: the unit receives wcmd in SRC, then rcmd plus its own data in SNK.
- i_unit_valid of non-selected units is ignored. i_req_valid outside IDLE is ignored.
- o_unit_data holds its last value outside SNK; consumers qualify it with o_unit_valid.
- Unselected command slices drive 0.

## Timing
- Reset (async assert, sync-released internally as plain flops): state=IDLE, data register=0, timeout counter=0. Outputs: o_req_ready=1 after reset; all other outputs 0.
- Reset mid-transaction aborts immediately. No o_done is issued.
- Accept at edge T (i_req_valid & o_req_ready). SRC runs from cycle T+1.
- Source valid in cycle T+1+k causes SNK in cycle T+2+k. Minimum done latency is 2 cycles after accept; o_req_ready returns at T+3+k.
- Throughput: at most one transfer per 3 cycles.
- Invalid-ID request accepted at T: o_done/o_err in cycle T+1, and o_req_ready=0 in that cycle.

## Configuration
- BUS_ROUTER_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT+1) clears on entering SRC and increments each SRC cycle without source valid.
  - After TIMEOUT such cycles: return to IDLE with o_done=o_err=1 for one cycle. No SNK cycle and no o_unit_valid are issued.
  - Source valid in the same cycle the counter hits TIMEOUT wins, giving a normal SNK.
- BUS_ROUTER_TIMEOUT_EN undefined: SRC waits indefinitely. The counter is absent and o_err is only raised for invalid IDs.

## Test plan
- Basic transfer: wid=1, rid=2, wcmd=3, rcmd=5, unit 1 returns 0xBEEF combinationally → SNK at T+2 with o_unit_data=0xBEEF, o_unit_valid=4'b0100, o_unit_cmd slice 2=5, o_done=1, o_err=0.
- Delayed source: unit 0 asserts valid after 4 SRC cycles with 0x1234 → o_unit_cmd_en[0] high for exactly 4 cycles, then SNK delivers 0x1234; o_req_ready=0 throughout.
- Same unit: wid=rid=3, data 0x00FF → SRC cmd=wcmd, then SNK on unit 3 with rcmd and 0x00FF.
- Invalid ID with N_UNITS=4: rid=6 → o_done=o_err=1 at T+1, no o_unit_valid or o_unit_cmd_en asserted.
- Timeout (macro on, TIMEOUT=15): source never valid → o_done=o_err=1 after 15 SRC cycles. With source valid on cycle 15 → normal SNK.
- Reset mid-SRC: drop i_Reset_n asynchronously → all outputs 0 immediately. After release, o_req_ready=1 and a fresh transfer completes normally.
